// File: rtl/conv_pkg.sv
// Shared types, default parameters and derived-size helpers for the strided 2-D convolution engine.
package conv_pkg;

    typedef enum logic [1:0] {IDLE, LOAD, CALC, OUT} conv_state_t;

    localparam int DEF_DATA_W = 8;
    localparam int DEF_IMG_M  = 7;
    localparam int DEF_KER_K  = 3;
    localparam int DEF_STRIDE = 2;
    localparam int DEF_FLIP   = 1;

    function automatic int out_n(input int m, input int k, input int s);
        if (s < 1 || k > m) return 1;
        return (m - k) / s + 1;
    endfunction

    // Full-precision sum of k*k unsigned products: never wraps.
    function automatic int acc_w(input int dw, input int k);
        return 2 * dw + $clog2(k * k);
    endfunction

    // Index width that stays at least one bit for single-entry ranges.
    function automatic int idx_w(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/conv_mac.sv
// Registered multiply-accumulate; clr restarts the sum (loading the current product when en is high).
module conv_mac #(
    parameter int DATA_W = 8,
    parameter int ACC_W  = 20
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              clr,
    input  logic              en,
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    output logic [ACC_W-1:0]  acc
);

    logic [ACC_W-1:0] prod;

    assign prod = ACC_W'(a) * ACC_W'(b);

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            acc <= '0;
        end else if (clr) begin
            acc <= en ? prod : '0;
        end else if (en) begin
            acc <= acc + prod;
        end
    end

endmodule

// File: rtl/conv2d_stream_engine.sv
// Frame-buffered strided 2-D convolution: load kernel, stream an image in, then compute one
// window per K*K MAC cycles and hand each full-precision sum out over a valid/ready port.
module conv2d_stream_engine
    import conv_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int IMG_M  = DEF_IMG_M,
    parameter int KER_K  = DEF_KER_K,
    parameter int STRIDE = DEF_STRIDE,
    parameter int FLIP   = DEF_FLIP,
    localparam int OUT_N = out_n(IMG_M, KER_K, STRIDE),
    localparam int ACC_W = acc_w(DATA_W, KER_K),
    localparam int KA_W  = idx_w(KER_K * KER_K),
    localparam int RC_W  = idx_w(OUT_N)
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              k_we,
    input  logic [KA_W-1:0]   k_addr,
    input  logic [DATA_W-1:0] k_data,
    input  logic              start,
    input  logic              pix_valid,
    output logic              pix_ready,
    input  logic [DATA_W-1:0] pix_data,
    output logic              res_valid,
    input  logic              res_ready,
    output logic [ACC_W-1:0]  res_data,
    output logic [RC_W-1:0]   res_row,
    output logic [RC_W-1:0]   res_col,
    output logic              busy,
    output logic              done,
    output logic [1:0]        fsm_state
);

    localparam int NPIX = IMG_M * IMG_M;
    localparam int NKER = KER_K * KER_K;
    localparam int PA_W = idx_w(NPIX);
    localparam int MC_W = $clog2(NKER + 1);
    localparam int KI_W = idx_w(KER_K);

    if (KER_K > IMG_M) begin : g_bad_kernel
        $error("conv2d_stream_engine: KER_K must not exceed IMG_M");
    end
    if (STRIDE < 1) begin : g_bad_stride
        $error("conv2d_stream_engine: STRIDE must be at least 1");
    end

    // Handshakes: a pixel moves on a clock edge where pix_valid & pix_ready, a result where
    // res_valid & res_ready; an offered result holds data/row/col until it is taken.
    conv_state_t       state, state_next;
    logic [PA_W-1:0]   pix_cnt, pix_addr;
    logic [MC_W-1:0]   mac_cnt;
    logic [KI_W-1:0]   ki, kj;
    logic [KA_W-1:0]   ker_addr;
    logic [RC_W-1:0]   out_row, out_col;
    logic [ACC_W-1:0]  acc;
    logic [DATA_W-1:0] ker_mem [NKER];
    logic [DATA_W-1:0] frame   [NPIX];
    logic [DATA_W-1:0] mac_a, mac_b;
    logic              pix_hs, res_hs, last_pix, mac_done, last_out, mac_en, mac_clr;
    int                row_i, col_i;

    assign fsm_state = state;
    assign res_row   = out_row;
    assign res_col   = out_col;

    always_comb begin
        state_next = state;
        pix_ready  = (state == LOAD);
        res_valid  = (state == OUT);
        busy       = (state != IDLE);
        pix_hs     = pix_ready & pix_valid;
        res_hs     = res_valid & res_ready;
        last_pix   = (pix_cnt == PA_W'(NPIX - 1));
        mac_done   = (mac_cnt == MC_W'(NKER));
        last_out   = (out_row == RC_W'(OUT_N - 1)) && (out_col == RC_W'(OUT_N - 1));
        mac_en     = (state == CALC) && !mac_done;
        mac_clr    = mac_en && (mac_cnt == '0);
        case (state)
            IDLE:    if (start) state_next = LOAD;
            LOAD:    if (pix_hs && last_pix) state_next = CALC;
            CALC:    if (mac_done) state_next = OUT;
            OUT:     if (res_hs) state_next = last_out ? IDLE : CALC;
            default: state_next = IDLE;
        endcase
    end

    // Window origin is (row*STRIDE, col*STRIDE); FLIP walks the kernel back to front.
    always_comb begin
        row_i    = int'(out_row) * STRIDE + int'(ki);
        col_i    = int'(out_col) * STRIDE + int'(kj);
        pix_addr = PA_W'(row_i * IMG_M + col_i);
        if (FLIP != 0) begin
            ker_addr = KA_W'((KER_K - 1 - int'(ki)) * KER_K + (KER_K - 1 - int'(kj)));
        end else begin
            ker_addr = KA_W'(int'(ki) * KER_K + int'(kj));
        end
        mac_a = frame[pix_addr];
        mac_b = ker_mem[ker_addr];
    end

    // Kernel is frozen while a frame is in flight; it survives reset.
    always_ff @(posedge clock) begin
        if (k_we && state == IDLE && int'(k_addr) < NKER) begin
            ker_mem[k_addr] <= k_data;
        end
        if (pix_hs) begin
            frame[pix_cnt] <= pix_data;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state    <= IDLE;
            pix_cnt  <= '0;
            mac_cnt  <= '0;
            ki       <= '0;
            kj       <= '0;
            out_row  <= '0;
            out_col  <= '0;
            res_data <= '0;
            done     <= 1'b0;
        end else begin
            state <= state_next;
            done  <= 1'b0;
            case (state)
                IDLE: pix_cnt <= '0;
                LOAD: begin
                    if (pix_hs) begin
                        pix_cnt <= pix_cnt + 1'b1;
                        if (last_pix) begin
                            mac_cnt <= '0;
                            ki      <= '0;
                            kj      <= '0;
                            out_row <= '0;
                            out_col <= '0;
                        end
                    end
                end
                CALC: begin
                    // The extra cycle after the last tap captures the finished sum.
                    if (mac_done) begin
                        res_data <= acc;
                    end else begin
                        mac_cnt <= mac_cnt + 1'b1;
                        if (kj == KI_W'(KER_K - 1)) begin
                            kj <= '0;
                            if (ki != KI_W'(KER_K - 1)) ki <= ki + 1'b1;
                        end else begin
                            kj <= kj + 1'b1;
                        end
                    end
                end
                OUT: begin
                    if (res_hs) begin
                        mac_cnt <= '0;
                        ki      <= '0;
                        kj      <= '0;
                        if (last_out) begin
                            done <= 1'b1;
                        end else if (out_col == RC_W'(OUT_N - 1)) begin
                            out_col <= '0;
                            out_row <= out_row + 1'b1;
                        end else begin
                            out_col <= out_col + 1'b1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    conv_mac #(
        .DATA_W(DATA_W),
        .ACC_W (ACC_W)
    ) u_mac (
        .clock(clock),
        .reset(reset),
        .clr  (mac_clr),
        .en   (mac_en),
        .a    (mac_a),
        .b    (mac_b),
        .acc  (acc)
    );

endmodule

// File: tb/tb_conv2d_stream_engine.sv
// Directed bench for conv2d_stream_engine: default 7x7/3x3/stride-2 true convolution plus an
// 8x8 cross-correlation instance sharing the kernel bus.
module tb_conv2d_stream_engine;

    logic        clk, reset, sel;
    logic        k_we, start, pix_valid, res_ready;
    logic [3:0]  k_addr;
    logic [7:0]  k_data, pix_data;

    logic        start7, pix_valid7, res_ready7, start8, pix_valid8, res_ready8;
    logic        pix_ready7, res_valid7, busy7, done7, pix_ready8, res_valid8, busy8, done8;
    logic [19:0] res_data7, res_data8;
    logic [1:0]  res_row7, res_col7, state7, res_row8, res_col8, state8;

    logic        m_valid, m_pix_ready, m_busy;
    logic [19:0] m_data;
    logic [1:0]  m_row, m_col, m_state;

    int          n_tests, n_fail, done_cnt7, done_cnt8;
    int          img [64];
    int          kmod [9];
    int          got_data [9];
    logic [23:0] exp_q [$];

    assign start7     = start & ~sel;
    assign pix_valid7 = pix_valid & ~sel;
    assign res_ready7 = res_ready & ~sel;
    assign start8     = start & sel;
    assign pix_valid8 = pix_valid & sel;
    assign res_ready8 = res_ready & sel;

    assign m_valid     = sel ? res_valid8 : res_valid7;
    assign m_pix_ready = sel ? pix_ready8 : pix_ready7;
    assign m_busy      = sel ? busy8 : busy7;
    assign m_data      = sel ? res_data8 : res_data7;
    assign m_row       = sel ? res_row8 : res_row7;
    assign m_col       = sel ? res_col8 : res_col7;
    assign m_state     = sel ? state8 : state7;

    conv2d_stream_engine dut7 (
        .clock(clk), .reset(reset), .k_we(k_we), .k_addr(k_addr), .k_data(k_data),
        .start(start7), .pix_valid(pix_valid7), .pix_ready(pix_ready7), .pix_data(pix_data),
        .res_valid(res_valid7), .res_ready(res_ready7), .res_data(res_data7),
        .res_row(res_row7), .res_col(res_col7), .busy(busy7), .done(done7), .fsm_state(state7)
    );

    conv2d_stream_engine #(.IMG_M(8), .FLIP(0)) dut8 (
        .clock(clk), .reset(reset), .k_we(k_we), .k_addr(k_addr), .k_data(k_data),
        .start(start8), .pix_valid(pix_valid8), .pix_ready(pix_ready8), .pix_data(pix_data),
        .res_valid(res_valid8), .res_ready(res_ready8), .res_data(res_data8),
        .res_row(res_row8), .res_col(res_col8), .busy(busy8), .done(done8), .fsm_state(state8)
    );

    // clock / reset
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(negedge clk) begin
        if (done7) done_cnt7++;
        if (done8) done_cnt8++;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // reference model: definition of strided convolution over the bench image/kernel
    function automatic int model(input int m, input int flip, input int r, input int c);
        int s, k;
        s = 0;
        for (int i = 0; i < 3; i++) begin
            for (int j = 0; j < 3; j++) begin
                k = flip ? (2 - i) * 3 + (2 - j) : i * 3 + j;
                s += img[(2 * r + i) * m + 2 * c + j] * kmod[k];
            end
        end
        return s;
    endfunction

    task automatic push_exp(input int m, input int flip);
        for (int r = 0; r < 3; r++) begin
            for (int c = 0; c < 3; c++) begin
                exp_q.push_back({2'(r), 2'(c), 20'(model(m, flip, r, c))});
            end
        end
    endtask

    task automatic fill_img(input int m, input int all255);
        for (int r = 0; r < m; r++) begin
            for (int c = 0; c < m; c++) img[r * m + c] = all255 ? 255 : r * m + c;
        end
    endtask

    // driver tasks
    task automatic write_ker(input int a, input int v);
        @(negedge clk);
        k_we   = 1'b1;
        k_addr = 4'(a);
        k_data = 8'(v);
        @(negedge clk);
        k_we   = 1'b0;
    endtask

    task automatic set_kernel(input int v_rest, input int v0);
        for (int a = 0; a < 9; a++) begin
            kmod[a] = (a == 0) ? v0 : v_rest;
            write_ker(a, kmod[a]);
        end
    endtask

    task automatic start_frame();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic load_frame(input int m, input int gaps);
        int idx, cyc;
        bit tog;
        idx = 0; cyc = 0; tog = 1'b0;
        while (idx < m * m && cyc < 1000) begin
            @(negedge clk);
            cyc++;
            if (gaps != 0 && tog) begin
                pix_valid = 1'b0;
            end else begin
                pix_valid = 1'b1;
                pix_data  = 8'(img[idx]);
                if (m_pix_ready) idx++;
            end
            tog = ~tog;
        end
        @(posedge clk);
        #1 pix_valid = 1'b0;
        if (idx < m * m) check("load_timeout", idx, m * m);
    endtask

    // scoreboard: pop one expected entry per result handshake
    task automatic collect(input int n, input int stall);
        int got, cyc;
        logic [23:0] e;
        got = 0; cyc = 0;
        while (got < n && cyc < 2000) begin
            @(negedge clk);
            cyc++;
            res_ready = 1'b0;
            if (m_valid) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_result", m_data, 0);
                    got = n;
                end else if (stall > 0) begin
                    check("hold_data", m_data, exp_q[0][19:0]);
                    check("hold_pos", {m_row, m_col}, exp_q[0][23:20]);
                    stall--;
                end else begin
                    res_ready = 1'b1;
                    e = exp_q.pop_front();
                    check("res_data", m_data, e[19:0]);
                    check("res_row", m_row, e[23:22]);
                    check("res_col", m_col, e[21:20]);
                    got_data[got] = int'(m_data);
                    got++;
                end
            end
        end
        if (got < n) check("collect_timeout", got, n);
        @(negedge clk);
        res_ready = 1'b0;
    endtask

    task automatic run_frame(input int m, input int flip, input int gaps, input int stall,
                             input int poke);
        int d0, lat;
        d0 = sel ? done_cnt8 : done_cnt7;
        push_exp(m, flip);
        start_frame();
        load_frame(m, gaps);
        if (poke != 0) begin
            check("busy_in_calc", m_busy, 1);
            write_ker(4, 9);
            start_frame();
            check("start_while_busy", m_pix_ready, 0);
        end else begin
            lat = 0;
            while (!m_valid && lat < 100) begin
                @(posedge clk);
                #1 lat++;
            end
            check("first_latency", lat, 10);
        end
        collect(9, stall);
        repeat (4) @(negedge clk);
        check("no_extra_result", m_valid, 0);
        check("exp_q_empty", exp_q.size(), 0);
        check("done_once", (sel ? done_cnt8 : done_cnt7) - d0, 1);
    endtask

    initial begin
        int d0;
        n_tests = 0; n_fail = 0; done_cnt7 = 0; done_cnt8 = 0;
        sel = 1'b0; reset = 1'b0; k_we = 1'b0; k_addr = '0; k_data = '0;
        start = 1'b0; pix_valid = 1'b0; pix_data = '0; res_ready = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_pix_ready", pix_ready7, 0);
        check("rst_res_valid", res_valid7, 0);
        check("rst_busy", busy7, 0);
        check("rst_done", done7, 0);
        check("rst_res_data", res_data7, 0);
        check("rst_pos", {res_row7, res_col7}, 0);
        check("rst_state", state7, 0);
        check("rst_busy8", busy8, 0);
        reset = 1'b1;

        // ramp image, unit kernel, with latency check
        set_kernel(1, 1);
        fill_img(7, 0);
        run_frame(7, 1, 0, 0, 0);
        check("t1_first", got_data[0], 72);
        check("t1_mid", got_data[4], 216);
        check("t1_last", got_data[8], 360);

        // downstream stall on result 0
        run_frame(7, 1, 0, 5, 0);

        // pixel gaps, plus start/k_we while busy
        run_frame(7, 1, 1, 0, 1);
        check("t5_first", got_data[0], 72);

        // async reset during CALC of result 4
        d0 = done_cnt7;
        push_exp(7, 1);
        start_frame();
        load_frame(7, 0);
        collect(4, 0);
        check("calc_before_rst", state7, 2);
        #2 reset = 1'b0;
        #1;
        check("arst_busy", busy7, 0);
        check("arst_res_valid", res_valid7, 0);
        check("arst_pix_ready", pix_ready7, 0);
        check("arst_res_data", res_data7, 0);
        check("arst_pos", {res_row7, res_col7}, 0);
        check("arst_state", state7, 0);
        @(negedge clk);
        reset = 1'b1;
        repeat (15) @(negedge clk);
        check("arst_idle_valid", res_valid7, 0);
        check("arst_no_done", done_cnt7 - d0, 0);
        exp_q.delete();
        run_frame(7, 1, 0, 0, 0);
        check("t6_first", got_data[0], 72);

        // single-tap kernel under true convolution
        set_kernel(0, 1);
        run_frame(7, 1, 0, 0, 0);
        check("t2_first", got_data[0], 16);
        check("t2_last", got_data[8], 48);

        // saturating operands, no wrap
        set_kernel(255, 255);
        fill_img(7, 1);
        run_frame(7, 1, 0, 0, 0);
        check("t3_first", got_data[0], 585225);
        check("t3_last", got_data[8], 585225);

        // 8x8 image, cross-correlation
        sel = 1'b1;
        set_kernel(1, 1);
        fill_img(8, 0);
        run_frame(8, 0, 0, 0, 0);
        check("t7_first", got_data[0], 81);
        check("t7_col2", got_data[1], 99);
        check("t7_last", got_data[8], 405);
        set_kernel(0, 1);
        run_frame(8, 0, 0, 0, 0);
        check("t2b_first", got_data[0], 0);
        check("t2b_last", got_data[8], 36);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
